fdc_disk_bridge: RTL

- Disk-side back end for the CPC floppy controller.
- Consumes the controller's 32-bit request word (disk_sr) and its write-FIFO byte stream.
- Produces the completion word (disk_cr) and the read-FIFO byte stream.
- Translates each request into a single host transaction (seek, read ID, read sector, write sector) on a valid/ready byte interface to the image-storage side (MCU/SD loader).

---
 rtl/fdc_disk_bridge_if.sv | 33 +++
 rtl/fdc_disk_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_disk_bridge_if.sv
// Host-side transaction bus of the FDC disk bridge.
// master: bridge (request, read/write byte streams); slave: MCU/SD image store.
interface fdc_disk_bridge_if;
    logic       host_req;
    logic [1:0] host_op;
    logic       host_drive;
    logic [6:0] host_cyl;
    logic       host_head;
    logic [7:0] host_sector;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       host_rready;
    logic [7:0] host_wdata;
    logic       host_wvalid;
    logic       host_wready;
    logic [7:0] host_id;
    logic       host_ack;
    logic       host_err;

    modport master (
        output host_req, host_op, host_drive, host_cyl, host_head,
        output host_sector, host_rready, host_wdata, host_wvalid,
        input  host_rdata, host_rvalid, host_wready, host_id,
        input  host_ack, host_err
    );

    modport slave (
        input  host_req, host_op, host_drive, host_cyl, host_head,
        input  host_sector, host_rready, host_wdata, host_wvalid,
        output host_rdata, host_rvalid, host_wready, host_id,
        output host_ack, host_err
    );
endinterface

// File: rtl/fdc_disk_bridge.sv
// Disk-side back end of the CPC floppy controller: turns disk_sr requests
// into one host transaction each and reports completion on disk_cr.
// Ports: clk/rst; disk_sr/disk_cr request/completion words; disk_data_in/
// disk_data_clkin to the read FIFO; disk_data_out/disk_data_clkout from the
// write FIFO; disk_present; busy; host (fdc_disk_bridge_if.master).
module fdc_disk_bridge #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter int unsigned FIFO_LAT     = 1,
    parameter logic [23:0] TIMEOUT      = 24'd8000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] disk_sr,
    output logic [31:0] disk_cr,
    output logic [7:0]  disk_data_in,
    output logic        disk_data_clkin,
    input  logic [7:0]  disk_data_out,
    output logic        disk_data_clkout,
    input  logic [1:0]  disk_present,
    output logic        busy,
    fdc_disk_bridge_if.master host
);
    localparam int CW = $clog2(SECTOR_BYTES) + 1;
    localparam logic [CW-1:0] SB  = CW'(SECTOR_BYTES);
    localparam logic [7:0]    LAT = 8'(FIFO_LAT);

    localparam logic [1:0] OP_SEEK  = 2'd0;
    localparam logic [1:0] OP_RDID  = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd3;

    typedef enum logic [2:0] {
        IDLE, RD, WFETCH, WDATA, HWAIT, DONE, RELEASE
    } state_t;

    state_t        state_q;
    logic [1:0]    op_q;
    logic          drv_q;
    logic [6:0]    cyl_q;
    logic          head_q;
    logic [7:0]    sec_q;
    logic [4:0]    req_q;
    logic [CW-1:0] cnt_q;
    logic [23:0]   wd_q;
    logic [7:0]    lat_q;
    logic          hreq_q;
    logic          rready_q;
    logic          wvalid_q;
    logic [7:0]    wdata_q;
    logic [7:0]    din_q;
    logic          clkin_q;
    logic          clkout_q;
    logic [7:0]    cr_sec_q;
    logic          cr_head_q;
    logic          done_q;
    logic          err_q;
    logic [1:0]    seek_q;

    // Bits of disk_sr this block never looks at.
    logic unused_sr;
    assign unused_sr = &{1'b0, disk_sr[31:26], disk_sr[19]};

    // Request scan: write > read > readID > seek, drive 0 first.
    logic       req_any;
    logic [4:0] req_bit;
    logic [1:0] req_op;
    logic       req_drv;

    always_comb begin
        req_any = 1'b1;
        req_bit = 5'd0;
        req_op  = OP_SEEK;
        req_drv = 1'b0;
        priority case (1'b1)
            disk_sr[20]: begin req_bit = 5'd20; req_op = OP_WRITE; end
            disk_sr[21]: begin req_bit = 5'd21; req_op = OP_WRITE; req_drv = 1'b1; end
            disk_sr[17]: begin req_bit = 5'd17; req_op = OP_READ; end
            disk_sr[18]: begin req_bit = 5'd18; req_op = OP_READ; req_drv = 1'b1; end
            disk_sr[22]: begin req_bit = 5'd22; req_op = OP_RDID; end
            disk_sr[23]: begin req_bit = 5'd23; req_op = OP_RDID; req_drv = 1'b1; end
            disk_sr[24]: begin req_bit = 5'd24; req_op = OP_SEEK; end
            disk_sr[25]: begin req_bit = 5'd25; req_op = OP_SEEK; req_drv = 1'b1; end
            default:     req_any = 1'b0;
        endcase
    end

    logic          wait_st;
    logic          wd_exp;
    logic          acc;
    logic          wacc;
    logic [CW-1:0] cnt_acc;
    logic [CW-1:0] cnt_w;
    logic          fin;
    logic          fin_err;
    logic [7:0]    fin_sec;

    assign wait_st = (state_q == RD) || (state_q == WDATA) || (state_q == HWAIT);
    assign wd_exp  = wait_st && (TIMEOUT != 24'd0) && (wd_q == TIMEOUT - 24'd1);
    assign acc     = (state_q == RD) && host.host_rvalid && rready_q;
    assign wacc    = (state_q == WDATA) && wvalid_q && host.host_wready;
    // Count including a byte taken in the same cycle as host_ack.
    assign cnt_acc = cnt_q + CW'(acc);
    assign cnt_w   = cnt_q + CW'(1);

    // Completion of the host transaction: ack or watchdog expiry.
    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_sec = sec_q;
        if (wait_st && host.host_ack) begin
            fin = 1'b1;
            unique case (state_q)
                RD:      fin_err = host.host_err || (cnt_acc != SB);
                HWAIT:   fin_err = host.host_err;
                default: fin_err = 1'b1;
            endcase
            if (state_q == HWAIT && op_q == OP_RDID) fin_sec = host.host_id;
        end else if (wd_exp) begin
            fin     = 1'b1;
            fin_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_SEEK;
            drv_q     <= 1'b0;
            cyl_q     <= 7'd0;
            head_q    <= 1'b0;
            sec_q     <= 8'd0;
            req_q     <= 5'd0;
            cnt_q     <= '0;
            wd_q      <= 24'd0;
            lat_q     <= 8'd0;
            hreq_q    <= 1'b0;
            rready_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            wdata_q   <= 8'd0;
            din_q     <= 8'd0;
            clkin_q   <= 1'b0;
            clkout_q  <= 1'b0;
            cr_sec_q  <= 8'd0;
            cr_head_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            seek_q    <= 2'b00;
        end else begin
            clkin_q  <= 1'b0;
            clkout_q <= 1'b0;
            // Watchdog restarts on every byte of progress and outside waits.
            wd_q <= (wait_st && !acc && !wacc) ? wd_q + 24'd1 : 24'd0;
            if (acc) begin
                din_q   <= host.host_rdata;
                clkin_q <= 1'b1;
                cnt_q   <= cnt_acc;
                if (cnt_acc == SB) rready_q <= 1'b0;
            end
            if (fin) begin
                state_q   <= DONE;
                hreq_q    <= 1'b0;
                rready_q  <= 1'b0;
                wvalid_q  <= 1'b0;
                cr_sec_q  <= fin_sec;
                cr_head_q <= head_q;
                err_q     <= fin_err;
                if (op_q == OP_SEEK) seek_q[drv_q] <= 1'b1;
                else                 done_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (req_any) begin
                            op_q   <= req_op;
                            drv_q  <= req_drv;
                            cyl_q  <= disk_sr[14:8];
                            head_q <= disk_sr[15];
                            sec_q  <= disk_sr[7:0];
                            req_q  <= req_bit;
                            hreq_q <= 1'b1;
                            cnt_q  <= '0;
                            lat_q  <= 8'd0;
                            unique case (req_op)
                                OP_WRITE: begin
                                    state_q  <= WFETCH;
                                    clkout_q <= 1'b1;
                                end
                                OP_READ: begin
                                    state_q  <= RD;
                                    rready_q <= 1'b1;
                                end
                                default: state_q <= HWAIT;
                            endcase
                        end
                    end
                    RD: ;
                    WFETCH: begin
                        // FIFO output settles LAT cycles after the pulse.
                        if (lat_q == LAT) begin
                            wdata_q  <= disk_data_out;
                            wvalid_q <= 1'b1;
                            state_q  <= WDATA;
                        end else begin
                            lat_q <= lat_q + 8'd1;
                        end
                    end
                    WDATA: begin
                        if (wacc) begin
                            wvalid_q <= 1'b0;
                            cnt_q    <= cnt_w;
                            if (cnt_w < SB) begin
                                state_q  <= WFETCH;
                                clkout_q <= 1'b1;
                                lat_q    <= 8'd0;
                            end else begin
                                state_q <= HWAIT;
                            end
                        end
                    end
                    HWAIT: ;
                    DONE: begin
                        if (disk_sr[16]) begin
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            seek_q  <= 2'b00;
                            state_q <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        // Hold off until the served request is withdrawn.
                        if (!disk_sr[req_q]) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign disk_cr = {cr_sec_q, 8'h00, 7'h00, cr_head_q, 1'b0,
                      disk_present, done_q, err_q, 1'b0, seek_q};
    assign disk_data_in     = din_q;
    assign disk_data_clkin  = clkin_q;
    assign disk_data_clkout = clkout_q;
    assign busy             = (state_q != IDLE);

    assign host.host_req    = hreq_q;
    assign host.host_op     = op_q;
    assign host.host_drive  = drv_q;
    assign host.host_cyl    = cyl_q;
    assign host.host_head   = head_q;
    assign host.host_sector = sec_q;
    assign host.host_rready = rready_q;
    assign host.host_wdata  = wdata_q;
    assign host.host_wvalid = wvalid_q;
endmodule
